// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - CPU bus decode with mirrored device maps, fixed-latency read return and OAM DMA engine
module bus_responder #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG    = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_PORT   = 16'h0004
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rw,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] dev_rdata,
  output logic                  cpu_rdy,
  output logic                  ram_cs,
  output logic                  ppu_cs,
  output logic                  apu_cs,
  output logic                  cart_cs,
  output logic [ADDR_WIDTH-1:0] dev_addr,
  output logic                  dev_rw,
  output logic [DATA_WIDTH-1:0] dev_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rdata_valid,
  output logic                  dma_active
);

  localparam logic [ADDR_WIDTH-1:0] PPU_BASE  = 'h2000;
  localparam logic [ADDR_WIDTH-1:0] APU_BASE  = 'h4000;
  localparam logic [ADDR_WIDTH-1:0] CART_BASE = 'h4020;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ALIGN2,
    S_READ,
    S_WRITE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] page_q, page_d;
  logic [7:0]            index_q, index_d;
  logic                  parity_q;
  logic                  rd_pend_q, rd_pend_d;

  logic                  cpu_rdy_q, cpu_rdy_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ppu_cs_q, ppu_cs_d;
  logic                  apu_cs_q, apu_cs_d;
  logic                  cart_cs_q, cart_cs_d;
  logic [ADDR_WIDTH-1:0] dev_addr_q, dev_addr_d;
  logic                  dev_rw_q, dev_rw_d;
  logic [DATA_WIDTH-1:0] dev_wdata_q, dev_wdata_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  cpu_rdata_valid_q, cpu_rdata_valid_d;
  logic                  dma_active_q, dma_active_d;

  logic                  cpu_acc;
  logic                  dma_start;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [ADDR_WIDTH-1:0] dec_in;
  logic                  dec_ram, dec_ppu, dec_apu, dec_cart;
  logic [ADDR_WIDTH-1:0] dec_addr;

  // cpu_rdy_q is low exactly while the FSM is outside IDLE, so CPU accesses only occur in IDLE
  assign cpu_acc   = valid & cpu_rdy_q;
  assign dma_start = cpu_acc & ~rw & (addr_in == DMA_REG);
  assign dma_addr  = {page_q, index_d};
  assign dec_in    = (state_q == S_IDLE) ? addr_in : dma_addr;

  always_comb begin
    dec_ram  = 1'b0;
    dec_ppu  = 1'b0;
    dec_apu  = 1'b0;
    dec_cart = 1'b0;
    dec_addr = '0;
    if (dec_in < PPU_BASE) begin
      dec_ram  = 1'b1;
      dec_addr = ADDR_WIDTH'(dec_in[10:0]);
    end else if (dec_in < APU_BASE) begin
      dec_ppu  = 1'b1;
      dec_addr = ADDR_WIDTH'(dec_in[2:0]);
    end else if (dec_in < CART_BASE) begin
      dec_apu  = 1'b1;
      dec_addr = ADDR_WIDTH'(dec_in[4:0]);
    end else begin
      dec_cart = 1'b1;
      dec_addr = dec_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      page_q    <= '0;
      index_q   <= '0;
      parity_q  <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      index_q   <= index_d;
      parity_q  <= ~parity_q;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    case (state_q)
      S_IDLE: begin
        if (dma_start) begin
          state_d = S_ALIGN;
          page_d  = data_in;
          index_d = 8'd0;
        end
      end
      S_ALIGN:  state_d = parity_q ? S_ALIGN2 : S_READ;
      S_ALIGN2: state_d = S_READ;
      S_READ:   state_d = S_WRITE;
      S_WRITE: begin
        if (index_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READ;
          index_d = index_q + 8'd1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed for the cycle being entered, so every port comes straight from a flop
  always_comb begin
    ram_cs_d          = 1'b0;
    ppu_cs_d          = 1'b0;
    apu_cs_d          = 1'b0;
    cart_cs_d         = 1'b0;
    dev_addr_d        = dev_addr_q;
    dev_rw_d          = 1'b1;
    dev_wdata_d       = dev_wdata_q;
    rd_pend_d         = 1'b0;
    cpu_rdata_d       = rd_pend_q ? dev_rdata : cpu_rdata_q;
    cpu_rdata_valid_d = rd_pend_q;
    cpu_rdy_d         = (state_d == S_IDLE);
    dma_active_d      = (state_d != S_IDLE);
    if (state_d == S_READ) begin
      ram_cs_d   = dec_ram;
      ppu_cs_d   = dec_ppu;
      apu_cs_d   = dec_apu;
      cart_cs_d  = dec_cart;
      dev_addr_d = dec_addr;
    end else if (state_d == S_WRITE) begin
      ppu_cs_d    = 1'b1;
      dev_addr_d  = OAM_PORT;
      dev_rw_d    = 1'b0;
      dev_wdata_d = dev_rdata;
    end else if (cpu_acc && !dma_start) begin
      ram_cs_d    = dec_ram;
      ppu_cs_d    = dec_ppu;
      apu_cs_d    = dec_apu;
      cart_cs_d   = dec_cart;
      dev_addr_d  = dec_addr;
      dev_rw_d    = rw;
      dev_wdata_d = data_in;
      rd_pend_d   = rw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdy_q         <= 1'b1;
      ram_cs_q          <= 1'b0;
      ppu_cs_q          <= 1'b0;
      apu_cs_q          <= 1'b0;
      cart_cs_q         <= 1'b0;
      dev_addr_q        <= '0;
      dev_rw_q          <= 1'b1;
      dev_wdata_q       <= '0;
      cpu_rdata_q       <= '0;
      cpu_rdata_valid_q <= 1'b0;
      dma_active_q      <= 1'b0;
    end else begin
      cpu_rdy_q         <= cpu_rdy_d;
      ram_cs_q          <= ram_cs_d;
      ppu_cs_q          <= ppu_cs_d;
      apu_cs_q          <= apu_cs_d;
      cart_cs_q         <= cart_cs_d;
      dev_addr_q        <= dev_addr_d;
      dev_rw_q          <= dev_rw_d;
      dev_wdata_q       <= dev_wdata_d;
      cpu_rdata_q       <= cpu_rdata_d;
      cpu_rdata_valid_q <= cpu_rdata_valid_d;
      dma_active_q      <= dma_active_d;
    end
  end

  assign cpu_rdy         = cpu_rdy_q;
  assign ram_cs          = ram_cs_q;
  assign ppu_cs          = ppu_cs_q;
  assign apu_cs          = apu_cs_q;
  assign cart_cs         = cart_cs_q;
  assign dev_addr        = dev_addr_q;
  assign dev_rw          = dev_rw_q;
  assign dev_wdata       = dev_wdata_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign cpu_rdata_valid = cpu_rdata_valid_q;
  assign dma_active      = dma_active_q;

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed vector bench for bus_responder
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr_in = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic        rw = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  dev_rdata = 8'h00;
  logic        cpu_rdy, ram_cs, ppu_cs, apu_cs, cart_cs;
  logic [15:0] dev_addr;
  logic        dev_rw;
  logic [7:0]  dev_wdata, cpu_rdata;
  logic        cpu_rdata_valid, dma_active;

  bus_responder dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .rw(rw),
    .valid(valid), .dev_rdata(dev_rdata), .cpu_rdy(cpu_rdy), .ram_cs(ram_cs),
    .ppu_cs(ppu_cs), .apu_cs(apu_cs), .cart_cs(cart_cs), .dev_addr(dev_addr),
    .dev_rw(dev_rw), .dev_wdata(dev_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rdata_valid(cpu_rdata_valid), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  wire [3:0]  cs   = {ram_cs, ppu_cs, apu_cs, cart_cs};
  wire [39:0] outs = {cpu_rdy, cs, dev_addr, dev_rw, dev_wdata, cpu_rdata, cpu_rdata_valid, dma_active};
  localparam logic [39:0] RESET_OUTS = {1'b1, 4'b0000, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};

  int tests = 0;
  int fails = 0;
  int cnt;

  // Edges since reset release; its LSB tracks the alignment parity
  always @(posedge clk or posedge reset)
    if (reset) cnt <= 0;
    else       cnt <= cnt + 1;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [3:0]  exp_cs;
    logic [15:0] exp_daddr;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] model_dec(input logic [15:0] a);
    if (a < 16'h2000)      return {4'b1000, 5'b0, a[10:0]};
    else if (a < 16'h4000) return {4'b0100, 13'b0, a[2:0]};
    else if (a < 16'h4020) return {4'b0010, 11'b0, a[4:0]};
    else                   return {4'b0001, a};
  endfunction

  function automatic logic [7:0] pat(input logic [7:0] p, input logic [7:0] i);
    return (i * 8'd7) ^ p ^ 8'h3C;
  endfunction

  task automatic run_dma(input logic [7:0] page, input bit odd, input bit pre_read,
                         input int exp_low, input string tag);
    int low = 0, nrd = 0, nwr = 0, err = 0, rdv = 0, guard = 0;
    logic [7:0]  ridx = 8'h00;
    logic [7:0]  last = 8'h00;
    logic [7:0]  b;
    logic [19:0] m;
    if (pre_read) begin
      while (cnt[0] != odd) @(negedge clk);
      addr_in = 16'h0010; rw = 1'b1; valid = 1'b1;
      @(negedge clk);
      check($sformatf("%s_pre_cs", tag), {cs, dev_addr}, {4'b1000, 16'h0010});
      dev_rdata = 8'hC3;
    end else begin
      while (cnt[0] == odd) @(negedge clk);
    end
    addr_in = 16'h4014; rw = 1'b0; data_in = page; valid = 1'b1;
    @(negedge clk);
    if (pre_read)
      check($sformatf("%s_pre_rdata", tag), {cpu_rdata_valid, cpu_rdata}, {1'b1, 8'hC3});
    while (cpu_rdy == 1'b0 && guard < 600) begin
      guard++;
      low++;
      dev_rdata = 8'h00;
      if (dma_active !== 1'b1) err++;
      if ($countones(cs) > 1) err++;
      if (cpu_rdata_valid) rdv++;
      if (|cs && dev_rw) begin
        m = model_dec({page, ridx});
        if ({cs, dev_addr} !== m) err++;
        b = pat(page, ridx);
        dev_rdata = b;
        last = b;
        ridx++;
        nrd++;
      end else if (|cs) begin
        if ({cs, dev_addr, dev_wdata} !== {4'b0100, 16'h0004, last} || nwr + 1 != nrd) err++;
        nwr++;
      end
      valid = low[0]; addr_in = 16'h0005; rw = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    check($sformatf("%s_low_cycles", tag), low, exp_low);
    check($sformatf("%s_reads", tag), nrd, 256);
    check($sformatf("%s_writes", tag), nwr, 256);
    check($sformatf("%s_seq_errors", tag), err, 0);
    check($sformatf("%s_rdata_pulses", tag), rdv, pre_read ? 1 : 0);
    check($sformatf("%s_exit", tag), {cpu_rdy, dma_active, cs, cpu_rdata_valid}, {1'b1, 1'b0, 4'b0000, 1'b0});
  endtask

  initial begin
    logic [7:0] last_rd;
    bit found;
    vecs[0]  = '{16'h0801, 1'b1, 8'h00, 8'h5A, 4'b1000, 16'h0001};
    vecs[1]  = '{16'h1FFF, 1'b1, 8'h00, 8'hA7, 4'b1000, 16'h07FF};
    vecs[2]  = '{16'h2000, 1'b1, 8'h00, 8'h11, 4'b0100, 16'h0000};
    vecs[3]  = '{16'h3FFE, 1'b0, 8'h33, 8'h00, 4'b0100, 16'h0006};
    vecs[4]  = '{16'h4000, 1'b1, 8'h00, 8'h42, 4'b0010, 16'h0000};
    vecs[5]  = '{16'h4015, 1'b0, 8'h0F, 8'h00, 4'b0010, 16'h0015};
    vecs[6]  = '{16'h4014, 1'b1, 8'h00, 8'h8C, 4'b0010, 16'h0014};
    vecs[7]  = '{16'h401F, 1'b1, 8'h00, 8'h6E, 4'b0010, 16'h001F};
    vecs[8]  = '{16'h4020, 1'b1, 8'h00, 8'h21, 4'b0001, 16'h4020};
    vecs[9]  = '{16'h8000, 1'b1, 8'h00, 8'h9E, 4'b0001, 16'h8000};
    vecs[10] = '{16'hFFFF, 1'b0, 8'hC4, 8'h00, 4'b0001, 16'hFFFF};
    last_rd = 8'h00;

    repeat (2) @(negedge clk);
    check("reset_values", outs, RESET_OUTS);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle%0d", i), {cpu_rdy, cs, cpu_rdata_valid, dma_active}, {1'b1, 4'b0000, 1'b0, 1'b0});
    end

    for (int i = 0; i < 11; i++) begin
      addr_in = vecs[i].addr; rw = vecs[i].rw; data_in = vecs[i].wdata; valid = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_cs", i), cs, vecs[i].exp_cs);
      check($sformatf("v%0d_dev_addr", i), dev_addr, vecs[i].exp_daddr);
      check($sformatf("v%0d_dev_rw", i), dev_rw, vecs[i].rw);
      if (!vecs[i].rw) check($sformatf("v%0d_wdata", i), dev_wdata, vecs[i].wdata);
      valid = 1'b0;
      dev_rdata = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("v%0d_cs_pulse", i), cs, 4'b0000);
      if (vecs[i].rw) last_rd = vecs[i].rdata;
      check($sformatf("v%0d_rdata", i), {cpu_rdata_valid, cpu_rdata}, {vecs[i].rw, last_rd});
    end

    addr_in = 16'h3FFE; rw = 1'b0; data_in = 8'h33; valid = 1'b1;
    @(negedge clk);
    check("pipe_write", {cs, dev_addr, dev_rw, dev_wdata}, {4'b0100, 16'h0006, 1'b0, 8'h33});
    addr_in = 16'h8000; rw = 1'b1;
    @(negedge clk);
    check("pipe_read", {cs, dev_addr, dev_rw, cpu_rdata_valid}, {4'b0001, 16'h8000, 1'b1, 1'b0});
    valid = 1'b0; dev_rdata = 8'hB7;
    @(negedge clk);
    check("pipe_rdata", {cpu_rdata_valid, cpu_rdata, cs}, {1'b1, 8'hB7, 4'b0000});

    addr_in = 16'h0123; rw = 1'b1; valid = 1'b1;
    @(negedge clk);
    dev_rdata = 8'h71; addr_in = 16'h2001;
    @(negedge clk);
    check("b2b_second", {cs, dev_addr, cpu_rdata_valid, cpu_rdata}, {4'b0100, 16'h0001, 1'b1, 8'h71});
    dev_rdata = 8'h72; valid = 1'b0;
    @(negedge clk);
    check("b2b_rdata", {cpu_rdata_valid, cpu_rdata}, {1'b1, 8'h72});
    @(negedge clk);

    run_dma(8'h02, 1'b0, 1'b0, 513, "dma_even");
    repeat (3) @(negedge clk);
    run_dma(8'h02, 1'b1, 1'b1, 514, "dma_odd");
    repeat (3) @(negedge clk);

    addr_in = 16'h4014; rw = 1'b0; data_in = 8'h02; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 400 && !found; g++) begin
      if (ram_cs && dev_addr == 16'h0264) found = 1'b1;
      else @(negedge clk);
    end
    check("abort_reach_idx100", found, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_async", outs, RESET_OUTS);
    @(negedge clk);
    check("abort_hold", outs, RESET_OUTS);
    reset = 1'b0;
    @(negedge clk);
    check("abort_after", {cpu_rdy, dma_active, cs}, {1'b1, 1'b0, 4'b0000});
    run_dma(8'h80, 1'b0, 1'b0, 513, "dma_cart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
